// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl
//   Sequencing controller for the multiply/divide unit. It accepts one
//   operation request at a time and pulses the matching unit start. It then
//   waits for that unit's completion and loads HI/LO from the selected unit.
//   Divide-by-zero is trapped before any unit is started.
//
// Configuration macro: MULT_DIV_TIMEOUT_EN
//   Defined   : a 7-bit watchdog bounds the WAIT state. Overrun aborts the
//               operation with a one-cycle timeout flag.
//   Undefined : no watchdog and no ABORT state. The timeout output is tied
//               to 0 and WAIT lasts until the selected unit finishes.
//
// Parameter
//   TIMEOUT_CYCLES  maximum WAIT cycles before abort (2..127, default 64)
//
// Ports
//   clock       in   sole clock, rising edge
//   reset       in   synchronous active-high reset
//   op_start    in   one-cycle request, honoured only when idle
//   op_is_div   in   0 = multiply, 1 = divide (sampled with op_start)
//   b_in[31:0]  in   divisor, sampled with op_start for the zero check
//   mult_done   in   multiplier completion pulse
//   div_done    in   divider completion pulse
//   mult_start  out  multiplier start pulse
//   div_start   out  divider start pulse
//   hi_write    out  HI register load enable
//   lo_write    out  LO register load enable
//   result_sel  out  HI/LO mux select: 0 = multiplier, 1 = divider
//   busy        out  high whenever an operation is in progress
//   done        out  completion pulse (success, div-by-zero or timeout)
//   div_zero    out  divide-by-zero exception pulse
//   timeout     out  watchdog exception pulse
module mult_div_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_is_div,
  input  logic [31:0] b_in,
  input  logic        mult_done,
  input  logic        div_done,
  output logic        mult_start,
  output logic        div_start,
  output logic        hi_write,
  output logic        lo_write,
  output logic        result_sel,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 127) begin : g_bad_timeout
    $error("mult_div_ctrl: TIMEOUT_CYCLES must be in 2..127");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_EXC    = 3'd4
`ifdef MULT_DIV_TIMEOUT_EN
    ,S_ABORT = 3'd5
`endif
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_op;
  logic   w_sel_done;

  // Only the selected unit's completion counts; the other unit is ignored.
  assign w_sel_done = r_op ? div_done : mult_done;

`ifdef MULT_DIV_TIMEOUT_EN
  localparam logic [6:0] WD_LIMIT = 7'(TIMEOUT_CYCLES - 1);
  logic [6:0] r_wd;

  // Cleared while launching, then counts every WAIT cycle. The abort fires
  // before the counter can pass WD_LIMIT, so it never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wd <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_wd <= '0;
    end else if (r_state == S_WAIT) begin
      r_wd <= r_wd + 7'd1;
    end
  end
`endif

  // State register and operation latch
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && op_start) begin
        r_op <= op_is_div;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (op_start) begin
          w_next = (op_is_div && (b_in == 32'd0)) ? S_EXC : S_LAUNCH;
        end
      end
      // A done seen during LAUNCH is stale and is never looked at.
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        // Completion takes priority over the watchdog limit.
        if (w_sel_done) begin
          w_next = S_WRITE;
        end
`ifdef MULT_DIV_TIMEOUT_EN
        else if (r_wd == WD_LIMIT) begin
          w_next = S_ABORT;
        end
`endif
      end
      S_WRITE: w_next = S_IDLE;
      S_EXC:   w_next = S_IDLE;
`ifdef MULT_DIV_TIMEOUT_EN
      S_ABORT: w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode. The outputs depend only on the state, so every pulse
  // lasts exactly one state-cycle.
  always_comb begin
    mult_start = 1'b0;
    div_start  = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    done       = 1'b0;
    div_zero   = 1'b0;
    timeout    = 1'b0;
    result_sel = r_op;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_LAUNCH: begin
        mult_start = ~r_op;
        div_start  = r_op;
      end
      S_WRITE: begin
        hi_write = 1'b1;
        lo_write = 1'b1;
        done     = 1'b1;
      end
      S_EXC: begin
        div_zero = 1'b1;
        done     = 1'b1;
      end
`ifdef MULT_DIV_TIMEOUT_EN
      S_ABORT: begin
        timeout = 1'b1;
        done    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
module tb_mult_div_ctrl;

  localparam int TO = 8;
`ifdef MULT_DIV_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        op_start;
  logic        op_is_div;
  logic [31:0] b_in;
  logic        mult_done;
  logic        div_done;
  logic        mult_start;
  logic        div_start;
  logic        hi_write;
  logic        lo_write;
  logic        result_sel;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout;

  int total = 0;
  int bad   = 0;
  bit m_sel = 1'b0;

  always #5 clock = ~clock;

  mult_div_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .op_start   (op_start),
    .op_is_div  (op_is_div),
    .b_in       (b_in),
    .mult_done  (mult_done),
    .div_done   (div_done),
    .mult_start (mult_start),
    .div_start  (div_start),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .result_sel (result_sel),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .timeout    (timeout)
  );

  // Expected outputs {mult_start,div_start,hi_write,lo_write,result_sel,
  // busy,done,div_zero,timeout} at cycle c of a transaction whose request is
  // driven at c=0 and whose final busy cycle is fin.
  function automatic logic [8:0] model(input int c, input bit op, input bit zero,
                                       input bit aborted, input int fin, input bit prev);
    if (c == 0)   return {4'b0, prev, 4'b0};
    if (c > fin)  return {4'b0, op, 4'b0};
    if (zero)     return {4'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    if (c == 1)   return {~op, op, 2'b00, op, 1'b1, 3'b000};
    if (c < fin)  return {4'b0, op, 1'b1, 3'b000};
    if (aborted)  return {4'b0, op, 1'b1, 1'b1, 1'b0, 1'b1};
    return {2'b00, 2'b11, op, 1'b1, 1'b1, 2'b00};
  endfunction

  task automatic step(input string tag, input int c, input logic [8:0] exp);
    logic [8:0] got;
    @(negedge clock);
    got = {mult_start, div_start, hi_write, lo_write, result_sel,
           busy, done, div_zero, timeout};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s c=%0d got=%b want=%b", tag, c, got, exp);
    end
    @(posedge clock);
    #1;
  endtask

  // One operation from request to the idle cycle after completion.
  // L: cycles from the start pulse to the selected unit's done.
  // stale: also pulse the selected done during the launch cycle.
  // noise: pulse the other unit's done (always in the first wait cycle).
  // spam: 0 none, 1 random op_start while busy, 2 op_start in the final busy cycle.
  task automatic run_txn(input string tag, input bit op, input logic [31:0] b,
                         input int L, input bit stale, input bit noise, input int spam);
    bit zero;
    bit aborted;
    bit sel_d;
    bit oth_d;
    int fin;
    zero    = op && (b == 32'd0);
    aborted = !zero && TO_EN && (L > TO);
    fin     = zero ? 1 : (aborted ? 2 + TO : 2 + L);
    for (int c = 0; c <= fin + 1; c++) begin
      op_start  = (c == 0) ||
                  (c <= fin && ((spam == 1 && $urandom_range(0, 1) == 1) ||
                                (spam == 2 && c == fin)));
      op_is_div = (c == 0) ? op : 1'($urandom);
      b_in      = (c == 0) ? b : (($urandom_range(0, 1) == 1) ? 32'd0 : $urandom);
      sel_d     = (!zero && c == 1 + L && c <= fin) || (stale && c == 1);
      oth_d     = noise && (c == 2 || $urandom_range(0, 2) == 0);
      mult_done = op ? oth_d : sel_d;
      div_done  = op ? sel_d : oth_d;
      step(tag, c, model(c, op, zero, aborted, fin, m_sel));
    end
    m_sel     = op;
    op_start  = 1'b0;
    mult_done = 1'b0;
    div_done  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    op_start  = 1'b0;
    op_is_div = 1'b0;
    b_in      = 32'd0;
    mult_done = 1'b0;
    div_done  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    step("reset", 0, 9'b0);
    reset = 1'b0;

    // Done pulses while idle change nothing.
    mult_done = 1'b1; div_done = 1'b1;
    step("idle_done", 0, 9'b0);
    mult_done = 1'b0; div_done = 1'b0;

    run_txn("mult32",     1'b0, 32'h1234, 32, 1'b0, 1'b0, 0);
    run_txn("divzero",    1'b1, 32'd0,     5, 1'b0, 1'b1, 0);
    run_txn("div_noise",  1'b1, 32'd7,    12, 1'b0, 1'b1, 0);
    run_txn("no_done",    1'b1, 32'd9,    40, 1'b0, 1'b0, 0);
    run_txn("stale",      1'b0, 32'd3,     3, 1'b1, 1'b0, 0);
    run_txn("limit_win",  1'b0, 32'd1,    TO, 1'b0, 1'b0, 0);
    run_txn("limit_over", 1'b1, 32'd1, TO + 1, 1'b0, 1'b1, 0);
    run_txn("drop_write", 1'b0, 32'd5,     2, 1'b0, 1'b0, 2);
    run_txn("drop_exc",   1'b1, 32'd0,     1, 1'b0, 1'b0, 2);
    run_txn("min_lat",    1'b1, 32'd2,     1, 1'b1, 1'b1, 1);

    // Reset in the fifth wait cycle of a divide; a late div_done is ignored.
    op_start = 1'b1; op_is_div = 1'b1; b_in = 32'd7;
    step("rst_req", 0, {4'b0, m_sel, 4'b0});
    op_start = 1'b0;
    step("rst_launch", 1, {1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 3'b000});
    for (int k = 2; k <= 5; k++) step("rst_wait", k, {4'b0, 1'b1, 1'b1, 3'b000});
    reset = 1'b1;
    step("rst_wait5", 6, {4'b0, 1'b1, 1'b1, 3'b000});
    reset = 1'b0; div_done = 1'b1;
    step("rst_after", 7, 9'b0);
    div_done = 1'b0;
    step("rst_idle", 8, 9'b0);
    m_sel = 1'b0;
    run_txn("post_rst", 1'b1, 32'd11, 4, 1'b0, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      bit          r_op;
      logic [31:0] r_b;
      r_op = 1'($urandom);
      r_b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_txn("rand", r_op, r_b, $urandom_range(1, 12), 1'($urandom), 1'($urandom),
              $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) step("rand_gap", 0, {4'b0, m_sel, 4'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
